// File: rtl/dlx_pkg.sv
// Shared types and constants for the DLX pipeline sequencer.
// Stage indices assume the default five-stage layout.
package dlx_pkg;

    localparam int XLEN_D = 32;

    localparam int IF_S = 0;
    localparam int ID_S = 1;
    localparam int EX_S = 2;
    localparam int WB_S = 4;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_FILL,
        ST_RUN,
        ST_ISTALL,
        ST_DSTALL
    } pipe_state_t;

endpackage

// File: rtl/dlx_pipe_ctrl_if.sv
// Handshake and status bundle between the core stages and the sequencer.
// The sequencer takes the slave side; the core (or bench) takes the master side.
interface dlx_pipe_ctrl_if #(
    parameter int XLEN    = 32,
    parameter int NSTAGES = 5
);

    logic                           i_data_valid;
    logic                           d_data_valid;
    logic                           d_req;
    logic                           load_use;
    logic                           redir_id;
    logic [XLEN-1:0]                redir_id_pc;
    logic                           redir_ex;
    logic [XLEN-1:0]                redir_ex_pc;
    logic [XLEN-1:0]                i_address;
    logic [NSTAGES-1:0][XLEN-1:0]   stage_pc;
    logic [NSTAGES-1:0]             stage_valid;
    logic [NSTAGES-1:0]             stage_en;
    logic                           started;

    modport master (
        output i_data_valid, d_data_valid, d_req,
        output load_use,
        output redir_id, redir_id_pc,
        output redir_ex, redir_ex_pc,
        input  i_address, stage_pc, stage_valid,
        input  stage_en, started
    );

    modport slave (
        input  i_data_valid, d_data_valid, d_req,
        input  load_use,
        input  redir_id, redir_id_pc,
        input  redir_ex, redir_ex_pc,
        output i_address, stage_pc, stage_valid,
        output stage_en, started
    );

endinterface

// File: rtl/dlx_stage_reg.sv
// One pipeline slot: PC plus valid flag, loaded under enable.
// A bubble loads the PC but forces the slot invalid.
module dlx_stage_reg #(
    parameter int              XLEN   = 32,
    parameter logic [XLEN-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en,
    input  logic            bubble,
    input  logic [XLEN-1:0] d_pc,
    input  logic            d_valid,
    output logic [XLEN-1:0] q_pc,
    output logic            q_valid
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_pc    <= RST_PC;
            q_valid <= 1'b0;
        end else if (en) begin
            q_pc    <= d_pc;
            q_valid <= d_valid & ~bubble;
        end
    end

endmodule

// File: rtl/dlx_pipe_ctrl.sv
// DLX pipeline sequencer: fetch PC, stage PC/valid chain,
// memory-handshake stalls, load-use bubbles and redirect flushes.
module dlx_pipe_ctrl
    import dlx_pkg::*;
#(
    parameter int              XLEN      = XLEN_D,
    parameter int              NSTAGES   = 5,
    parameter int              MEM_STAGE = 3,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic       clk,
    input  logic       reset_n,
    dlx_pipe_ctrl_if.slave bus
);

    localparam logic [XLEN-1:0] PC_INC = XLEN'(XLEN / 8);

    pipe_state_t state;
    pipe_state_t state_nx;

    logic [NSTAGES-1:0][XLEN-1:0] spc;
    logic [NSTAGES-1:0][XLEN-1:0] dpc;
    logic [NSTAGES-1:0]           sv;
    logic [NSTAGES-1:0]           dv;
    logic [NSTAGES-1:0]           en;
    logic [NSTAGES-1:0]           bub;
    logic [XLEN-1:0]              pc_nx;

    logic active;
    logic dstall;
    logic rex;
    logic rid;
    logic lu;
    logic ist;
    logic started_q;

    assign active = state inside {ST_RUN, ST_ISTALL, ST_DSTALL};

    // Conditions are built mutually exclusive, highest priority first.
    always_comb begin
        dstall = active & bus.d_req
               & sv[MEM_STAGE] & ~bus.d_data_valid;
        rex = active & ~dstall
            & bus.redir_ex & sv[EX_S];
        rid = active & ~dstall & ~rex
            & bus.redir_id & sv[ID_S];
        lu  = active & ~dstall & ~rex & ~rid
            & bus.load_use & sv[ID_S];
        ist = active & ~dstall & ~rex & ~rid & ~lu
            & ~bus.i_data_valid;
    end

    always_comb begin
        en       = '0;
        bub      = '0;
        state_nx = state;
        pc_nx    = spc[IF_S] + PC_INC;
        unique case (state)
            ST_RESET: state_nx = ST_FILL;
            ST_FILL: begin
                if (bus.i_data_valid) begin
                    en       = '1;
                    state_nx = ST_RUN;
                end
            end
            default: begin
                state_nx = ST_RUN;
                unique case (1'b1)
                    dstall: state_nx = ST_DSTALL;
                    rex: begin
                        en        = '1;
                        bub[IF_S] = 1'b1;
                        bub[ID_S] = 1'b1;
                        bub[EX_S] = 1'b1;
                        pc_nx     = bus.redir_ex_pc;
                    end
                    rid: begin
                        en        = '1;
                        bub[IF_S] = 1'b1;
                        bub[ID_S] = 1'b1;
                        pc_nx     = bus.redir_id_pc;
                    end
                    lu: begin
                        en        = '1;
                        en[IF_S]  = 1'b0;
                        en[ID_S]  = 1'b0;
                        bub[EX_S] = 1'b1;
                    end
                    ist: begin
                        en        = '1;
                        en[IF_S]  = 1'b0;
                        bub[ID_S] = 1'b1;
                        state_nx  = ST_ISTALL;
                    end
                    default: en = '1;
                endcase
            end
        endcase
    end

    // Slot 0 is the fetch PC; ID is fed by the completed fetch.
    always_comb begin
        dpc[IF_S] = pc_nx;
        dv[IF_S]  = 1'b1;
        for (int k = 1; k < NSTAGES; k++) begin
            dpc[k] = spc[k-1];
            dv[k]  = (k == ID_S) ? 1'b1 : sv[k-1];
        end
    end

    for (genvar k = 0; k < NSTAGES; k++) begin : g_st
        dlx_stage_reg #(
            .XLEN   (XLEN),
            .RST_PC ((k == IF_S) ? RESET_PC : '0)
        ) u_reg (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (en[k]),
            .bubble  (bub[k]),
            .d_pc    (dpc[k]),
            .d_valid (dv[k]),
            .q_pc    (spc[k]),
            .q_valid (sv[k])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_RESET;
            started_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_FILL && bus.i_data_valid)
                started_q <= 1'b1;
        end
    end

    assign bus.i_address   = spc[IF_S];
    assign bus.stage_pc    = spc;
    assign bus.stage_valid = sv;
    assign bus.stage_en    = en;
    assign bus.started     = started_q;

endmodule

// File: tb/tb_dlx_pipe_ctrl.sv
// Directed-vector bench for dlx_pipe_ctrl (XLEN=32, NSTAGES=5).
// Expected values are hand-traced through the pipeline.
module tb_dlx_pipe_ctrl;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    dlx_pipe_ctrl_if #(.XLEN(32), .NSTAGES(5)) bus ();

    dlx_pipe_ctrl #(
        .XLEN      (32),
        .NSTAGES   (5),
        .MEM_STAGE (3),
        .RESET_PC  (32'h0)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_data_valid = 1'b1;
        bus.d_data_valid = 1'b1;
        bus.d_req        = 1'b0;
        bus.load_use     = 1'b0;
        bus.redir_id     = 1'b0;
        bus.redir_id_pc  = '0;
        bus.redir_ex     = 1'b0;
        bus.redir_ex_pc  = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_iaddr"}, bus.i_address, 32'h0);
        chk({tag, "_started"}, 32'(bus.started), 32'h0);
        chk({tag, "_valid"}, 32'(bus.stage_valid), 32'h0);
        chk({tag, "_en"}, 32'(bus.stage_en), 32'h0);
        for (int k = 0; k < 5; k++)
            chk($sformatf("%s_pc%0d", tag, k),
                bus.stage_pc[k], 32'h0);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        idle_inputs();
        bus.i_data_valid = 1'b0;

        tick();
        tick();
        chk_reset_outputs("rst");

        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("fill_iaddr%0d", i),
                bus.i_address, 32'h0);
            chk($sformatf("fill_started%0d", i),
                32'(bus.started), 32'h0);
            if (i < 2) tick();
        end
        bus.i_data_valid = 1'b1;
        tick();
        chk("first_started", 32'(bus.started), 32'h1);
        chk("first_id_valid", 32'(bus.stage_valid[1]), 32'h1);
        chk("first_iaddr", bus.i_address, 32'h4);
        chk("first_id_pc", bus.stage_pc[1], 32'h0);

        // Straight-line run: WB sees 0,4,8,... from the 4th edge.
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("run_iaddr%0d", i),
                bus.i_address, 32'(4 + 4 * i));
            if (i < 3) begin
                chk($sformatf("run_wbv%0d", i),
                    32'(bus.stage_valid[4]), 32'h0);
            end else begin
                chk($sformatf("run_wbv%0d", i),
                    32'(bus.stage_valid[4]), 32'h1);
                chk($sformatf("run_wbpc%0d", i),
                    bus.stage_pc[4], 32'(4 * (i - 3)));
            end
        end

        // EX and ID redirect together: EX wins.
        bus.redir_ex    = 1'b1;
        bus.redir_ex_pc = 32'h100;
        bus.redir_id    = 1'b1;
        bus.redir_id_pc = 32'h200;
        #1;
        chk("rex_en", 32'(bus.stage_en), 32'h1f);
        tick();
        chk("rex_iaddr", bus.i_address, 32'h100);
        chk("rex_v", 32'(bus.stage_valid), 32'h18);
        chk("rex_pc3", bus.stage_pc[3], 32'd28);
        bus.redir_ex = 1'b0;

        // ID redirect from an empty ID is ignored.
        tick();
        chk("rid_ign_iaddr", bus.i_address, 32'h104);
        chk("rid_ign_v1", 32'(bus.stage_valid[1]), 32'h1);
        chk("rid_ign_pc1", bus.stage_pc[1], 32'h100);

        bus.redir_id_pc = 32'h200;
        tick();
        chk("rid_iaddr", bus.i_address, 32'h200);
        chk("rid_v1", 32'(bus.stage_valid[1]), 32'h0);
        chk("rid_v2", 32'(bus.stage_valid[2]), 32'h1);
        chk("rid_pc2", bus.stage_pc[2], 32'h100);
        bus.redir_id = 1'b0;

        tick();
        chk("pre_lu_iaddr", bus.i_address, 32'h204);

        // Single-cycle load-use: one bubble into EX.
        bus.load_use = 1'b1;
        #1;
        chk("lu_en", 32'(bus.stage_en), 32'h1c);
        tick();
        bus.load_use = 1'b0;
        chk("lu_iaddr", bus.i_address, 32'h204);
        chk("lu_pc1", bus.stage_pc[1], 32'h200);
        chk("lu_v2", 32'(bus.stage_valid[2]), 32'h0);
        chk("lu_pc4", bus.stage_pc[4], 32'h100);
        chk("lu_v4", 32'(bus.stage_valid[4]), 32'h1);
        tick();
        chk("post_lu_iaddr", bus.i_address, 32'h208);
        chk("post_lu_pc2", bus.stage_pc[2], 32'h200);
        chk("post_lu_v2", 32'(bus.stage_valid[2]), 32'h1);
        tick();
        chk("pre_ds_pc3", bus.stage_pc[3], 32'h200);
        chk("pre_ds_v3", 32'(bus.stage_valid[3]), 32'h1);

        // Data stall for 4 cycles with a pending EX redirect.
        bus.d_req        = 1'b1;
        bus.d_data_valid = 1'b0;
        bus.redir_ex     = 1'b1;
        bus.redir_ex_pc  = 32'h300;
        #1;
        chk("ds_en", 32'(bus.stage_en), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("ds_iaddr%0d", i),
                bus.i_address, 32'h20c);
            chk($sformatf("ds_pc3_%0d", i),
                bus.stage_pc[3], 32'h200);
            chk($sformatf("ds_pc2_%0d", i),
                bus.stage_pc[2], 32'h204);
        end
        bus.d_data_valid = 1'b1;
        tick();
        chk("ds_rel_iaddr", bus.i_address, 32'h300);
        chk("ds_rel_pc3", bus.stage_pc[3], 32'h204);
        chk("ds_rel_pc4", bus.stage_pc[4], 32'h200);
        chk("ds_rel_v", 32'(bus.stage_valid), 32'h18);
        bus.d_req    = 1'b0;
        bus.redir_ex = 1'b0;

        // Instruction stall for one cycle.
        bus.i_data_valid = 1'b0;
        #1;
        chk("is_en", 32'(bus.stage_en), 32'h1e);
        tick();
        chk("is_iaddr", bus.i_address, 32'h300);
        chk("is_v1", 32'(bus.stage_valid[1]), 32'h0);
        bus.i_data_valid = 1'b1;
        tick();
        chk("post_is_iaddr", bus.i_address, 32'h304);
        chk("post_is_pc1", bus.stage_pc[1], 32'h300);
        chk("post_is_v1", 32'(bus.stage_valid[1]), 32'h1);

        // PC wrap at the top of the address space.
        bus.redir_id    = 1'b1;
        bus.redir_id_pc = 32'hffff_fffc;
        tick();
        bus.redir_id = 1'b0;
        chk("wrap_top", bus.i_address, 32'hffff_fffc);
        tick();
        chk("wrap_zero", bus.i_address, 32'h0);
        chk("wrap_pc1", bus.stage_pc[1], 32'hffff_fffc);
        tick();
        tick();
        chk("wrap_pc3", bus.stage_pc[3], 32'hffff_fffc);
        chk("wrap_iaddr8", bus.i_address, 32'h8);

        // Async reset in the middle of a data stall.
        bus.d_req        = 1'b1;
        bus.d_data_valid = 1'b0;
        bus.redir_ex     = 1'b1;
        bus.redir_ex_pc  = 32'h400;
        tick();
        chk("ds2_iaddr", bus.i_address, 32'h8);
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("arst");
        idle_inputs();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        chk("rec_fill_iaddr", bus.i_address, 32'h0);
        chk("rec_fill_started", 32'(bus.started), 32'h0);
        tick();
        chk("rec_started", 32'(bus.started), 32'h1);
        chk("rec_iaddr", bus.i_address, 32'h4);
        chk("rec_v1", 32'(bus.stage_valid[1]), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dlx_pipe_ctrl.md
# dlx_pipe_ctrl

Parametrised pipeline sequencer for the DLX core. It owns the fetch PC, the per-stage PC/valid shift chain and the post-reset fetch qualifier, and adds what the fixed five-stage top lacks: stalls driven by the instruction and data memory valid handshakes, load-use bubbles, and prioritised flushes from ID and EX redirects. It sits beside the IF/ID/EX/MEM/WB stages and replaces their hand-wired PC and reset-delay flops.

## Interface
- XLEN, 32, address/PC width in bits
- NSTAGES, 5, pipeline depth (stage 0 = IF … NSTAGES-1 = WB); legal 4..8
- MEM_STAGE, 3, index of the stage that issues data accesses (< NSTAGES-1)
- RESET_PC, 0, fetch address after reset

- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- i_data_valid  in  1  instruction word on ROM read port is valid this cycle
- d_data_valid  in  1  data access by MEM stage completed this cycle
- d_req  in  1  MEM-stage instruction performs a load or store
- load_use  in  1  ID instruction needs a result still being loaded in EX
- redir_id  in  1  jump resolved in ID
- redir_id_pc  in  XLEN  target for redir_id
- redir_ex  in  1  branch/jump-register resolved in EX
- redir_ex_pc  in  XLEN  target for redir_ex
- i_address  out  XLEN  current fetch address (ROM)
- stage_pc  out  NSTAGES×XLEN  PC held by each stage
- stage_valid  out  NSTAGES  stage holds a real (non-bubble) instruction
- stage_en  out  NSTAGES  stage register may load this cycle
- started  out  1  first post-reset fetch has completed

## Operation
- FSM states: RESET, FILL, RUN, ISTALL, DSTALL.
- RESET: entered asynchronously; pc=RESET_PC; all stage_valid=0, stage_pc=0, started=0, stage_en=0. Leaves to FILL on first clock after reset_n deasserts.
- FILL: waits for i_data_valid; on it, started=1, ID becomes valid, → RUN. No instruction is issued before this (prevents double execution).
- RUN: every cycle, if no stall, pc += XLEN/8 (wraps modulo 2^XLEN); stage k takes PC/valid of stage k-1.
- Stall priority (highest first):
  1. DSTALL: d_req & stage_valid[MEM_STAGE] & !d_data_valid → all stage_en=0, pc frozen, redirects ignored (EX is frozen so they persist).
  2. load_use & stage_valid[1]: IF and ID hold, EX receives bubble (valid=0), later stages advance.
  3. ISTALL: !i_data_valid in RUN → IF holds, ID receives bubble, later stages advance.
- Redirect (only when not DSTALL): redir_ex wins over redir_id. redir_ex: pc←redir_ex_pc, stages 0..1 valid cleared, EX passes a bubble onward. redir_id (alone): pc←redir_id_pc, stage 0 bubbled. A redirect overrides load_use and ISTALL in the same cycle.
- Redirect input ignored when its source stage is not valid.
- stage_en reflects the above exactly; stages use it as their register enable.

## Timing
- i_address is registered; changes one cycle after the deciding event.
- Redirect latency: target on i_address the cycle after redir_* sampled high.
- Load-use: exactly one bubble per asserted cycle.
- DSTALL releases the cycle d_data_valid is sampled high; pipeline advances that same edge.
- reset_n assert mid-stall or mid-redirect: all outputs return to reset values immediately (async), no pending redirect survives.
- ISTALL and DSTALL together: DSTALL governs; on its release ISTALL evaluated normally.

## Structure
- Package dlx_pkg: state enum pipe_state_t, stage index constants (IF_S, ID_S, EX_S, WB_S), XLEN default.
- One sub-module natural: dlx_stage_reg (PC+valid flop with enable and synchronous bubble), instantiated NSTAGES times in a generate loop.

## Test plan
- Reset release with i_data_valid low 3 cycles → i_address=0, started=0 until valid; then started=1, stage_valid[1]=1, i_address=4.
- Straight-line run of 6 instructions, NSTAGES=5 → stage_pc[4] shows 0,4,8… in order, 4-cycle fill latency.
- redir_ex=1, target 0x100, together with redir_id target 0x200 → i_address=0x100 next cycle, stage_valid[0..2] cleared.
- d_req with d_data_valid low 4 cycles → all stage_pc frozen 4 cycles, redir_ex ignored until release.
- load_use for 1 cycle → exactly one bubble at EX, i_address held one cycle.
- pc=0xFFFFFFFC, RUN → i_address wraps to 0; reset_n dropped mid-DSTALL → all outputs reset asynchronously.
